pwm_cfg_sequencer: RTL

//   Configuration sequencer for the centered-PWM core. Accepts duty/period requests over a

---
 rtl/pwm_cfg_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/pwm_cfg_sequencer.sv
// Configuration sequencer for the centered-PWM core: validates duty/period requests and
// commits them (optionally as a stepped duty ramp) only on period boundaries.
module pwm_cfg_sequencer #(
  parameter int unsigned MAX_DUTY  = 99,
  parameter int unsigned RAMP_STEP = 1,
  parameter int unsigned RAMP_HOLD = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [6:0] req_duty,
  input  logic [1:0] req_pow2,
  input  logic [1:0] req_pow5,
  input  logic       req_ramp,
  input  logic       period_tick,
  input  logic       stop,
  output logic [6:0] duty_percent_out,
  output logic [1:0] pow2_out,
  output logic [1:0] pow5_out,
  output logic       busy,
  output logic       err_pulse
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RAMP, S_STOPPED} state_t;

  localparam logic [6:0] MAX7  = 7'(MAX_DUTY);
  localparam logic [6:0] STEP7 = 7'(RAMP_STEP);
  localparam logic [7:0] HOLD8 = 8'(RAMP_HOLD);

  state_t     r_state, w_state_nxt;
  logic [6:0] r_tgt_duty, w_tgt_duty_nxt;
  logic [1:0] r_tgt_pow2, w_tgt_pow2_nxt;
  logic [1:0] r_tgt_pow5, w_tgt_pow5_nxt;
  logic       r_tgt_ramp, w_tgt_ramp_nxt;
  logic [7:0] r_hold, w_hold_nxt;
  logic [6:0] r_duty, w_duty_nxt;
  logic [1:0] r_pow2, w_pow2_nxt;
  logic [1:0] r_pow5, w_pow5_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_err, w_err_nxt;

  logic       w_accept;
  logic       w_reject;
  logic [6:0] w_diff;
  logic [6:0] w_step_duty;
  logic [7:0] w_hold_inc;

  assign req_ready        = rstn && (r_state == S_IDLE) && !stop;
  assign w_accept         = req_valid && req_ready;
  assign w_reject         = w_accept && (req_duty > MAX7);
  assign w_hold_inc       = r_hold + 8'd1;
  assign duty_percent_out = r_duty;
  assign pow2_out         = r_pow2;
  assign pow5_out         = r_pow5;
  assign busy             = r_busy;
  assign err_pulse        = r_err;

  // Next ramp value: move by RAMP_STEP but land exactly on the target when closer than a step.
  always_comb begin
    w_diff      = '0;
    w_step_duty = r_tgt_duty;
    if (r_tgt_duty >= r_duty) begin
      w_diff = r_tgt_duty - r_duty;
      if (w_diff > STEP7) w_step_duty = r_duty + STEP7;
    end else begin
      w_diff = r_duty - r_tgt_duty;
      if (w_diff > STEP7) w_step_duty = r_duty - STEP7;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tgt_duty_nxt = r_tgt_duty;
    w_tgt_pow2_nxt = r_tgt_pow2;
    w_tgt_pow5_nxt = r_tgt_pow5;
    w_tgt_ramp_nxt = r_tgt_ramp;
    w_hold_nxt     = r_hold;
    w_duty_nxt     = r_duty;
    w_pow2_nxt     = r_pow2;
    w_pow5_nxt     = r_pow5;
    w_err_nxt      = w_reject;

    case (r_state)
      S_IDLE: begin
        if (w_accept && !w_reject) begin
          w_tgt_duty_nxt = req_duty;
          w_tgt_pow2_nxt = req_pow2;
          w_tgt_pow5_nxt = req_pow5;
          w_tgt_ramp_nxt = req_ramp;
          w_state_nxt    = S_ARMED;
        end
      end
      S_ARMED: begin
        if (period_tick) begin
          w_pow2_nxt = r_tgt_pow2;
          w_pow5_nxt = r_tgt_pow5;
          if (!r_tgt_ramp || (r_duty == r_tgt_duty)) begin
            w_duty_nxt  = r_tgt_duty;
            w_state_nxt = S_IDLE;
          end else begin
            w_duty_nxt  = w_step_duty;
            w_hold_nxt  = '0;
            w_state_nxt = (w_step_duty == r_tgt_duty) ? S_IDLE : S_RAMP;
          end
        end
      end
      S_RAMP: begin
        if (period_tick) begin
          if (w_hold_inc == HOLD8) begin
            w_duty_nxt = w_step_duty;
            w_hold_nxt = '0;
            if (w_step_duty == r_tgt_duty) w_state_nxt = S_IDLE;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
      S_STOPPED: begin
        w_duty_nxt = '0;
        if (!stop) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Stop on a period boundary overrides whatever the state logic above decided.
    if (stop && period_tick) begin
      w_duty_nxt     = '0;
      w_pow2_nxt     = r_pow2;
      w_pow5_nxt     = r_pow5;
      w_tgt_duty_nxt = '0;
      w_tgt_pow2_nxt = '0;
      w_tgt_pow5_nxt = '0;
      w_tgt_ramp_nxt = 1'b0;
      w_hold_nxt     = '0;
      w_state_nxt    = S_STOPPED;
    end

    w_busy_nxt = (w_state_nxt == S_ARMED) || (w_state_nxt == S_RAMP);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_tgt_duty <= '0;
      r_tgt_pow2 <= '0;
      r_tgt_pow5 <= '0;
      r_tgt_ramp <= 1'b0;
      r_hold     <= '0;
      r_duty     <= '0;
      r_pow2     <= '0;
      r_pow5     <= '0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tgt_duty <= w_tgt_duty_nxt;
      r_tgt_pow2 <= w_tgt_pow2_nxt;
      r_tgt_pow5 <= w_tgt_pow5_nxt;
      r_tgt_ramp <= w_tgt_ramp_nxt;
      r_hold     <= w_hold_nxt;
      r_duty     <= w_duty_nxt;
      r_pow2     <= w_pow2_nxt;
      r_pow5     <= w_pow5_nxt;
      r_busy     <= w_busy_nxt;
      r_err      <= w_err_nxt;
    end
  end

endmodule
